uart_response_sender: RTL
=========================

# uart_response_sender

Two-byte response framer directly upstream of the UART transmitter. On a request from the sensor controller, it latches a response code and a value. It then pushes them out in a fixed order, code first and value second, by handshaking each byte into the transmitter. It reports packet completion, and it reports a timeout if the transmitter stalls.

## Interface
Parameters:
- TIMEOUT_CYCLES, 8192: maximum cycles spent waiting on the transmitter per byte. This exceeds one 10-bit frame at 434 clocks per bit (4340).

Ports:
- clock, input, 1: sole clock; all logic on the rising edge.
- reset_n, input, 1: reset, asynchronous assert, active-low.
- send_request, input, 1: one-cycle request; sampled only while ready=1.
- response_code, input, 8: first byte; captured with send_request.
- response_value, input, 8: second byte; captured with send_request.
- ready, output, 1: high in IDLE only.
- packet_done, output, 1: one-cycle pulse after the second byte's done edge.
- timeout_error, output, 1: one-cycle pulse on abort.
- tx_has_data, output, 1: start strobe to the transmitter.
- tx_data, output, 8: byte presented to the transmitter; stable while tx_has_data=1.
- tx_busy, input, 1: transmitter is_transmitting.
- tx_done, input, 1: transmitter transmission_done. It may stay high for two or more cycles, so only its rising edge is used.

## Operation
- The request is accepted only in IDLE. While not ready, send_request is ignored and nothing is queued.
- On acceptance:
  - buffer[0]=response_code and buffer[1]=response_value.
  - byte_idx=0.
  - Go to START.
- START:
  - tx_has_data=1 and tx_data=buffer[byte_idx].
  - Hold until tx_busy is sampled 1, then drop tx_has_data and go to WAIT_DONE.
- WAIT_DONE:
  - tx_done_q registers tx_done.
  - done_edge = tx_done & ~tx_done_q.
  - On done_edge go to NEXT.
- NEXT:
  - If byte_idx==1, go to FINISH.
  - Otherwise byte_idx=1 and go to START.
  - START must not reassert tx_has_data while tx_busy=1 or tx_done=1. This guarantees the transmitter has returned to idle.
- FINISH: packet_done=1 for one cycle, then go to IDLE.
- Timeout:
  - timer clears on every entry to START or WAIT_DONE and increments each cycle in those states.
  - When timer reaches TIMEOUT_CYCLES-1: timeout_error=1 for one cycle, tx_has_data=0, and go to IDLE.
  - The remaining byte is discarded and packet_done is not pulsed.
- Timer width is $clog2(TIMEOUT_CYCLES+1) bits, unsigned, with no wrap (it saturates by exiting the state).
- If done_edge and the timeout terminal count coincide, done_edge wins: no error, and the FSM proceeds.

## Timing
- Reset values:
  - ready=1; packet_done, timeout_error and tx_has_data=0.
  - tx_data=8'h00.
  - State IDLE, byte_idx=0, timer=0, tx_done_q=0.
- All outputs are registered.
- Request to tx_has_data high: 1 cycle. Request to ready low: 1 cycle.
- done_edge to next tx_has_data: at least 2 cycles, which also satisfies the transmitter's cleanup cycle.
- Second done_edge to packet_done: 2 cycles (NEXT, then FINISH). ready rises the cycle after packet_done.
- reset_n low mid-packet: immediate return to reset values. The partial byte on the line is the transmitter's concern.

## Structure
- Shared package or include uart_defs:
  - state encodings IDLE=3'd0, START=3'd1, WAIT_DONE=3'd2, NEXT=3'd3, FINISH=3'd4.
  - PACKET_BYTES=2.
  - default TIMEOUT_CYCLES.
- One natural sub-module: rising_edge_detect (clock, reset_n, in → pulse), used on tx_done.
- The top level instantiates this block feeding UART_TX: tx_has_data→has_data, tx_data→data_to_send, is_transmitting→tx_busy, transmission_done→tx_done.

## Test plan
- **Nominal packet:** code=8'hA5, value=8'h3C, using a UART_TX model at 434 clocks per bit → serial line shows A5 then 3C, LSB first; exactly one packet_done; ready low throughout.
- **Request while busy:** a second send_request (8'h11/8'h22) mid-packet → ignored; only A5/3C are sent; no second packet_done.
- **Long done pulse:** a stub holds tx_done high for 3 cycles → exactly one byte advance per done assertion; tx_has_data not reasserted until tx_done=0 and tx_busy=0.
- **Stalled transmitter:** a stub never raises tx_busy → timeout_error pulses exactly 8192 cycles after START entry; tx_has_data=0; ready=1; no packet_done.
- **Stall on second byte:** the first byte completes, then tx_done never rises → timeout_error; the next request restarts at byte_idx=0 with the new code.
- **Reset mid-packet:** reset_n pulled low during the first byte's WAIT_DONE → all outputs at reset values asynchronously; a fresh request after release sends both bytes correctly.

Source files
------------

// File: rtl/uart_response_sender_pkg.sv
// Shared types and constants for the two-byte UART response framer.
package uart_response_sender_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_DONE = 3'd2,
    NEXT      = 3'd3,
    FINISH    = 3'd4
  } state_e;

  localparam int unsigned PACKET_BYTES           = 2;
  localparam int unsigned BYTE_IDX_W             = $clog2(PACKET_BYTES);
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 8192;

  typedef struct packed {
    logic [7:0] code;
    logic [7:0] value;
  } response_t;

  // Byte 0 is the response code, byte 1 the value.
  function automatic logic [7:0] response_byte(input response_t r,
                                               input logic [BYTE_IDX_W-1:0] idx);
    return (idx == '0) ? r.code : r.value;
  endfunction

endpackage

// File: rtl/uart_response_sender_rising_edge_detect.sv
// One-cycle pulse on a 0->1 transition of a level input; the pulse is combinational.
module uart_response_sender_rising_edge_detect (
  input  logic clock,
  input  logic reset_n,
  input  logic in_i,
  output logic pulse_c
);

  logic in_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      in_q <= 1'b0;
    end else begin
      in_q <= in_i;
    end
  end

  assign pulse_c = in_i & ~in_q;

endmodule

// File: rtl/uart_response_sender.sv
// Latches a code/value pair and hands them to the UART transmitter one byte at a
// time, pulsing packet_done on completion or timeout_error if the transmitter stalls.
module uart_response_sender
  import uart_response_sender_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       send_request,
  input  logic [7:0] response_code,
  input  logic [7:0] response_value,
  output logic       ready,
  output logic       packet_done,
  output logic       timeout_error,
  output logic       tx_has_data,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  input  logic       tx_done
);

  localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [BYTE_IDX_W-1:0] LAST_IDX = BYTE_IDX_W'(PACKET_BYTES - 1);

  state_e                state_q, state_d;
  response_t             buf_q, buf_d;
  logic [BYTE_IDX_W-1:0] byte_idx_q, byte_idx_d;
  logic [TIMER_W-1:0]    timer_q, timer_d;
  logic                  ready_q, ready_d;
  logic                  packet_done_q, packet_done_d;
  logic                  timeout_error_q, timeout_error_d;
  logic                  tx_has_data_q, tx_has_data_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  done_edge_c;
  logic                  abort_c;
  logic                  timer_last_c;

  uart_response_sender_rising_edge_detect u_done_edge (
    .clock   (clock),
    .reset_n (reset_n),
    .in_i    (tx_done),
    .pulse_c (done_edge_c)
  );

  assign timer_last_c = (timer_q == TIMER_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      buf_q           <= '0;
      byte_idx_q      <= '0;
      timer_q         <= '0;
      ready_q         <= 1'b1;
      packet_done_q   <= 1'b0;
      timeout_error_q <= 1'b0;
      tx_has_data_q   <= 1'b0;
      tx_data_q       <= 8'h00;
    end else begin
      state_q         <= state_d;
      buf_q           <= buf_d;
      byte_idx_q      <= byte_idx_d;
      timer_q         <= timer_d;
      ready_q         <= ready_d;
      packet_done_q   <= packet_done_d;
      timeout_error_q <= timeout_error_d;
      tx_has_data_q   <= tx_has_data_d;
      tx_data_q       <= tx_data_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    buf_d           = buf_q;
    byte_idx_d      = byte_idx_q;
    timer_d         = timer_q;
    ready_d         = ready_q;
    packet_done_d   = 1'b0;
    timeout_error_d = 1'b0;
    tx_has_data_d   = tx_has_data_q;
    tx_data_d       = tx_data_q;
    abort_c         = 1'b0;

    case (state_q)
      IDLE: begin
        if (send_request) begin
          buf_d         = '{code: response_code, value: response_value};
          byte_idx_d    = '0;
          timer_d       = '0;
          ready_d       = 1'b0;
          tx_has_data_d = 1'b1;
          tx_data_d     = response_code;
          state_d       = START;
        end
      end
      // Strobe is only raised once the transmitter is fully idle; busy counts
      // as acceptance only while our strobe is up.
      START: begin
        timer_d = timer_q + TIMER_W'(1);
        if (tx_has_data_q && tx_busy) begin
          tx_has_data_d = 1'b0;
          timer_d       = '0;
          state_d       = WAIT_DONE;
        end else if (timer_last_c) begin
          abort_c = 1'b1;
        end else if (!tx_has_data_q && !tx_busy && !tx_done) begin
          tx_has_data_d = 1'b1;
        end
      end
      // A done edge on the terminal count still counts as success.
      WAIT_DONE: begin
        timer_d = timer_q + TIMER_W'(1);
        if (done_edge_c) begin
          state_d = NEXT;
        end else if (timer_last_c) begin
          abort_c = 1'b1;
        end
      end
      NEXT: begin
        timer_d = '0;
        if (byte_idx_q == LAST_IDX) begin
          packet_done_d = 1'b1;
          state_d       = FINISH;
        end else begin
          byte_idx_d = byte_idx_q + BYTE_IDX_W'(1);
          tx_data_d  = response_byte(buf_q, byte_idx_q + BYTE_IDX_W'(1));
          state_d    = START;
        end
      end
      FINISH: begin
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: begin
        ready_d       = 1'b1;
        tx_has_data_d = 1'b0;
        state_d       = IDLE;
      end
    endcase

    if (abort_c) begin
      timeout_error_d = 1'b1;
      tx_has_data_d   = 1'b0;
      ready_d         = 1'b1;
      timer_d         = '0;
      byte_idx_d      = '0;
      state_d         = IDLE;
    end
  end

  assign ready         = ready_q;
  assign packet_done   = packet_done_q;
  assign timeout_error = timeout_error_q;
  assign tx_has_data   = tx_has_data_q;
  assign tx_data       = tx_data_q;

endmodule
